acc_writeback: RTL and testbench
================================

// Module: acc_writeback
// PURPOSE
//  Writeback stage directly downstream of the ALU. Commits the ALU result to the accumulator or to a
//  register in a 2^REG_BIT_CNT-entry register file, and latches the zero/less/greater flags.
//  Its outputs close the loop back into the ALU: acc_out drives in1_acc and rd_data drives in2_reg.
//  It also evaluates branch conditions against the committed flags and counts retired writebacks.
// PARAMETERS
//  DATA_WIDTH   8  width of accumulator, register entries and ALU result
//  REG_BIT_CNT  3  register index width; register file depth = 2**REG_BIT_CNT
//  CNTR_WIDTH   8  width of retired-writeback counter (wraps)
// PORTS
//  clk          in   1            rising-edge clock
//  rst_n        in   1            asynchronous active-low reset
//  wb_valid     in   1            ALU result present this cycle
//  wb_ready     out  1            stage accepts result; = ~stall
//  stall        in   1            hold request from control; blocks all commits
//  wb_data      in   DATA_WIDTH   ALU data_out
//  wb_zero_f    in   1            ALU zero_f
//  wb_ls_z_f    in   1            ALU ls_z_f
//  wb_gr_z_f    in   1            ALU gr_z_f
//  wb_dest_acc  in   1            1: write accumulator, 0: write regfile[wb_reg_idx]
//  wb_reg_idx   in   REG_BIT_CNT  destination register when wb_dest_acc=0
//  wb_flag_we   in   1            update flag register on commit
//  rd_idx       in   REG_BIT_CNT  register file read index
//  rd_data      out  DATA_WIDTH   regfile[rd_idx], combinational; feeds ALU in2_reg
//  acc_out      out  DATA_WIDTH   accumulator; feeds ALU in1_acc
//  flags_out    out  3            {gr, ls, zero} committed flags
//  br_req       in   1            branch condition evaluation request
//  br_cond      in   2            00 always, 01 zero, 10 less-than-zero, 11 greater-than-zero
//  br_valid     out  1            one-cycle pulse, 1 cycle after br_req
//  br_take      out  1            condition result, valid while br_valid=1
//  retired_cnt  out  CNTR_WIDTH   count of committed writebacks
// BEHAVIOUR
//  - Reset (async, rst_n=0): acc_out=0, all regs=0, flags_out=3'b001 (zero set), br_valid=0,
//    br_take=0, retired_cnt=0. Reset asserted mid-stall or mid-branch clears everything;
//    a request pending in that cycle is dropped.
//  - Commit = wb_valid & wb_ready, taking effect on the rising edge. Data, flags and counter update
//    in the same edge. Latency from ALU result to acc_out/register visible: 1 cycle.
//  - wb_dest_acc=1 writes acc; 0 writes regfile[wb_reg_idx]. Exactly one target per commit.
//  - wb_flag_we=1 on commit loads {wb_gr_z_f, wb_ls_z_f, wb_zero_f}; otherwise flags are held.
//    Flags may update on a regfile write; flags never change without a commit.
//  - stall=1: wb_ready=0, no state changes except br_valid/br_take (branch eval continues).
//  - retired_cnt += 1 per commit, modulo 2**CNTR_WIDTH (0xFF -> 0x00 at default width).
//  - Branch: br_req sampled at edge N; at edge N, br_take <= cond(flags_out before edge N) and
//    br_valid <= 1, so the result is visible for cycle N+1. br_valid drops the next cycle
//    unless br_req is held. A flag commit in the same cycle as br_req is NOT seen (old flags).
//    br_cond=00 -> 1; 01 -> zero; 10 -> ls; 11 -> gr.
//  - rd_data is a pure combinational array read. Same-cycle read/write of the same index: see CONFIGURATION.
//  - No width conversion: wb_data is stored verbatim; signedness is the ALU's concern.
// CONFIGURATION
//  WB_BYPASS_EN defined: if commit & ~wb_dest_acc & (wb_reg_idx==rd_idx), rd_data=wb_data same
//   cycle (forward); acc_out is likewise forwarded from wb_data when committing to acc.
//  WB_BYPASS_EN undefined: rd_data/acc_out show the pre-write value until the next cycle;
//   control must insert a bubble for back-to-back dependency.
// TESTING
//  1 reset: rst_n=0 mid-run -> acc_out=0, rd_data=0 for all idx, flags_out=3'b001, retired_cnt=0.
//  2 commit wb_data=8'h5A, dest_acc=1, flag_we=1, flags {0,0,0} -> next cycle acc_out=8'h5A,
//    flags_out=3'b000, retired_cnt=1.
//  3 stall=1 with wb_valid=1, data 8'h33 to r3 -> wb_ready=0, r3 unchanged, count unchanged;
//    release stall -> r3=8'h33 one cycle later.
//  4 flags={1,0,0} (gr); br_req, br_cond=11 -> br_valid=1, br_take=1 next cycle; same cycle commit
//    flags {0,0,1} with br_cond=01 -> br_take=0 (old flags used).
//  5 255 commits then 1 more (CNTR_WIDTH=8) -> retired_cnt 8'hFF then 8'h00.
//  6 write r2=8'hC3 with rd_idx=2 same cycle -> rd_data=8'hC3 that cycle if WB_BYPASS_EN,
//    else old value that cycle and 8'hC3 on the next.

Source files
------------

// File: rtl/acc_writeback.sv
// acc_writeback: commits ALU results to acc/regfile, latches flags, evaluates branches, counts retirements
// Optional WB_BYPASS_EN forwards same-cycle commits onto rd_data and acc_out.
module acc_writeback #(
  parameter int DATA_WIDTH  = 8,
  parameter int REG_BIT_CNT = 3,
  parameter int CNTR_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wb_valid,
  output logic                   wb_ready,
  input  logic                   stall,
  input  logic [DATA_WIDTH-1:0]  wb_data,
  input  logic                   wb_zero_f,
  input  logic                   wb_ls_z_f,
  input  logic                   wb_gr_z_f,
  input  logic                   wb_dest_acc,
  input  logic [REG_BIT_CNT-1:0] wb_reg_idx,
  input  logic                   wb_flag_we,
  input  logic [REG_BIT_CNT-1:0] rd_idx,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic [DATA_WIDTH-1:0]  acc_out,
  output logic [2:0]             flags_out,
  input  logic                   br_req,
  input  logic [1:0]             br_cond,
  output logic                   br_valid,
  output logic                   br_take,
  output logic [CNTR_WIDTH-1:0]  retired_cnt
);
  localparam int DEPTH = 1 << REG_BIT_CNT;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  commit;
  logic                  cond;
  assign wb_ready = ~stall;
  assign commit   = wb_valid & ~stall;
  // flags_out = {gr, ls, zero}
  assign cond = br_cond[1] ? (br_cond[0] ? flags_out[2] : flags_out[1])
                           : (br_cond[0] ? flags_out[0] : 1'b1);
`ifdef WB_BYPASS_EN
  assign rd_data = (commit & ~wb_dest_acc & (wb_reg_idx == rd_idx)) ? wb_data : regs[rd_idx];
  assign acc_out = (commit & wb_dest_acc) ? wb_data : acc;
`else
  assign rd_data = regs[rd_idx];
  assign acc_out = acc;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      flags_out   <= 3'b001;
      retired_cnt <= '0;
      br_valid    <= 1'b0;
      br_take     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      br_valid <= br_req;
      br_take  <= br_req & cond;
      if (commit) begin
        if (wb_dest_acc) acc <= wb_data;
        else regs[wb_reg_idx] <= wb_data;
        if (wb_flag_we) flags_out <= {wb_gr_z_f, wb_ls_z_f, wb_zero_f};
        retired_cnt <= retired_cnt + CNTR_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_acc_writeback.sv
// tb_acc_writeback: randomized and directed checks of acc_writeback against a behavioural model
module tb_acc_writeback;
  logic       clk = 0, rst_n = 0;
  logic       wb_valid = 0, stall = 0, wb_zero_f = 0, wb_ls_z_f = 0, wb_gr_z_f = 0;
  logic       wb_dest_acc = 0, wb_flag_we = 0, br_req = 0;
  logic [7:0] wb_data = 0;
  logic [2:0] wb_reg_idx = 0, rd_idx = 0;
  logic [1:0] br_cond = 0;
  logic       wb_ready, br_valid, br_take;
  logic [7:0] rd_data, acc_out, retired_cnt;
  logic [2:0] flags_out;
  int tests = 0, fails = 0;
  logic [7:0] m_acc, m_cnt;
  logic [7:0] m_regs [8];
  logic [2:0] m_flags;
  logic       m_bv, m_bt;

  acc_writeback dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready), .stall(stall),
    .wb_data(wb_data), .wb_zero_f(wb_zero_f), .wb_ls_z_f(wb_ls_z_f), .wb_gr_z_f(wb_gr_z_f),
    .wb_dest_acc(wb_dest_acc), .wb_reg_idx(wb_reg_idx), .wb_flag_we(wb_flag_we),
    .rd_idx(rd_idx), .rd_data(rd_data), .acc_out(acc_out), .flags_out(flags_out),
    .br_req(br_req), .br_cond(br_cond), .br_valid(br_valid), .br_take(br_take),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic committing();
    return wb_valid && !stall;
  endfunction

  function automatic logic [7:0] exp_rd();
`ifdef WB_BYPASS_EN
    if (committing() && !wb_dest_acc && wb_reg_idx == rd_idx) return wb_data;
`endif
    return m_regs[rd_idx];
  endfunction

  function automatic logic [7:0] exp_acc();
`ifdef WB_BYPASS_EN
    if (committing() && wb_dest_acc) return wb_data;
`endif
    return m_acc;
  endfunction

  task automatic idle();
    wb_valid = 0; stall = 0; wb_flag_we = 0; br_req = 0; wb_dest_acc = 0;
    wb_data = 0; wb_reg_idx = 0; br_cond = 0;
    {wb_gr_z_f, wb_ls_z_f, wb_zero_f} = 3'b000;
  endtask

  task automatic model_reset();
    m_acc = 0; m_cnt = 0; m_flags = 3'b001; m_bv = 0; m_bt = 0;
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
  endtask

  task automatic step();
    logic [3:0] sel;
    @(posedge clk);
    sel = {m_flags[2], m_flags[1], m_flags[0], 1'b1};
    m_bv = br_req;
    m_bt = br_req && sel[br_cond];
    if (committing()) begin
      if (wb_dest_acc) m_acc = wb_data;
      else m_regs[wb_reg_idx] = wb_data;
      if (wb_flag_we) m_flags = {wb_gr_z_f, wb_ls_z_f, wb_zero_f};
      m_cnt = m_cnt + 8'd1;
    end
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    idle();
    model_reset();
    @(negedge clk) rst_n = 1;
    #1;
  endtask

  task automatic commit(input logic [7:0] d, input logic acc, input logic [2:0] r,
                        input logic fwe, input logic [2:0] f);
    wb_valid = 1; wb_data = d; wb_dest_acc = acc; wb_reg_idx = r; wb_flag_we = fwe;
    {wb_gr_z_f, wb_ls_z_f, wb_zero_f} = f;
    step();
    wb_valid = 0; wb_flag_we = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (acc_out !== 8'h00) begin fails++; $display("FAIL reset_acc got %h exp 00", acc_out); end
    tests++; if (flags_out !== 3'b001) begin fails++; $display("FAIL reset_flags got %b exp 001", flags_out); end
    tests++; if (retired_cnt !== 8'h00) begin fails++; $display("FAIL reset_cnt got %h exp 00", retired_cnt); end
    tests++; if (br_valid !== 1'b0 || br_take !== 1'b0) begin fails++; $display("FAIL reset_br got %b%b exp 00", br_valid, br_take); end
    tests++; if (wb_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", wb_ready); end
  endtask

  task automatic test_commit_acc();
    commit(8'h5A, 1, 0, 1, 3'b000);
    #1;
    tests++; if (acc_out !== 8'h5A) begin fails++; $display("FAIL acc_commit got %h exp 5a", acc_out); end
    tests++; if (flags_out !== 3'b000) begin fails++; $display("FAIL acc_flags got %b exp 000", flags_out); end
    tests++; if (retired_cnt !== 8'd1) begin fails++; $display("FAIL acc_cnt got %0d exp 1", retired_cnt); end
  endtask

  task automatic test_stall();
    logic [7:0] c0;
    c0 = m_cnt;
    stall = 1; wb_valid = 1; wb_data = 8'h33; wb_dest_acc = 0; wb_reg_idx = 3; rd_idx = 3;
    #1;
    tests++; if (wb_ready !== 1'b0) begin fails++; $display("FAIL stall_ready got %b exp 0", wb_ready); end
    step(); step();
    tests++; if (rd_data !== m_regs[3] || m_regs[3] !== 8'h00) begin fails++; $display("FAIL stall_hold got %h exp 00", rd_data); end
    tests++; if (retired_cnt !== c0) begin fails++; $display("FAIL stall_cnt got %h exp %h", retired_cnt, c0); end
    stall = 0;
    step();
    wb_valid = 0;
    #1;
    tests++; if (rd_data !== 8'h33) begin fails++; $display("FAIL stall_release got %h exp 33", rd_data); end
    tests++; if (retired_cnt !== c0 + 8'd1) begin fails++; $display("FAIL stall_release_cnt got %h exp %h", retired_cnt, c0 + 8'd1); end
  endtask

  task automatic test_branch();
    commit(8'h01, 1, 0, 1, 3'b100);
    br_req = 1; br_cond = 2'b11;
    step();
    tests++; if (br_valid !== 1'b1 || br_take !== 1'b1) begin fails++; $display("FAIL br_gr got %b%b exp 11", br_valid, br_take); end
    br_cond = 2'b01;
    commit(8'h02, 1, 0, 1, 3'b001);
    tests++; if (br_valid !== 1'b1 || br_take !== 1'b0) begin fails++; $display("FAIL br_oldflags got %b%b exp 10", br_valid, br_take); end
    tests++; if (flags_out !== 3'b001) begin fails++; $display("FAIL br_newflags got %b exp 001", flags_out); end
    br_req = 0;
    step();
    tests++; if (br_valid !== 1'b0) begin fails++; $display("FAIL br_drop got %b exp 0", br_valid); end
    br_req = 1; br_cond = 2'b01;
    step();
    br_req = 0;
    tests++; if (br_valid !== 1'b1 || br_take !== 1'b1) begin fails++; $display("FAIL br_zero got %b%b exp 11", br_valid, br_take); end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    for (int i = 0; i < 255; i++) commit(8'($urandom), 1'($urandom), 3'($urandom), 0, 3'b000);
    tests++; if (retired_cnt !== 8'hFF) begin fails++; $display("FAIL cnt_ff got %h exp ff", retired_cnt); end
    commit(8'h00, 1, 0, 0, 3'b000);
    tests++; if (retired_cnt !== 8'h00) begin fails++; $display("FAIL cnt_wrap got %h exp 00", retired_cnt); end
  endtask

  task automatic test_bypass();
    logic [7:0] old;
    commit(8'h11, 0, 2, 0, 3'b000);
    old = m_regs[2];
    wb_valid = 1; wb_data = 8'hC3; wb_dest_acc = 0; wb_reg_idx = 2; rd_idx = 2;
    #1;
`ifdef WB_BYPASS_EN
    tests++; if (rd_data !== 8'hC3) begin fails++; $display("FAIL bypass_same got %h exp c3", rd_data); end
`else
    tests++; if (rd_data !== old) begin fails++; $display("FAIL bypass_same got %h exp %h", rd_data, old); end
`endif
    step();
    wb_valid = 0;
    #1;
    tests++; if (rd_data !== 8'hC3) begin fails++; $display("FAIL bypass_next got %h exp c3", rd_data); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      wb_valid = 1'($urandom); stall = ($urandom_range(0, 3) == 0);
      wb_data = 8'($urandom); wb_dest_acc = 1'($urandom); wb_reg_idx = 3'($urandom);
      wb_flag_we = 1'($urandom); {wb_gr_z_f, wb_ls_z_f, wb_zero_f} = 3'($urandom);
      rd_idx = 3'($urandom); br_req = 1'($urandom); br_cond = 2'($urandom);
      #1;
      tests++; if (rd_data !== exp_rd() || acc_out !== exp_acc() || wb_ready !== !stall) begin
        fails++; $display("FAIL rnd_comb[%0d] rd %h/%h acc %h/%h rdy %b", n, rd_data, exp_rd(), acc_out, exp_acc(), wb_ready);
      end
      step();
      tests++; if (flags_out !== m_flags || retired_cnt !== m_cnt || br_valid !== m_bv || (m_bv && br_take !== m_bt)) begin
        fails++; $display("FAIL rnd_seq[%0d] flags %b/%b cnt %h/%h bv %b/%b bt %b/%b", n, flags_out, m_flags, retired_cnt, m_cnt, br_valid, m_bv, br_take, m_bt);
      end
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i);
      #1;
      tests++; if (rd_data !== m_regs[i]) begin fails++; $display("FAIL rnd_reg%0d got %h exp %h", i, rd_data, m_regs[i]); end
    end
  endtask

  task automatic test_reset_midrun();
    stall = 1; wb_valid = 1; wb_data = 8'hEE; br_req = 1; br_cond = 2'b00;
    #2 rst_n = 0;
    @(posedge clk); #1;
    tests++; if (acc_out !== 8'h00 || flags_out !== 3'b001 || retired_cnt !== 8'h00 || br_valid !== 1'b0) begin
      fails++; $display("FAIL midreset acc %h flags %b cnt %h bv %b exp 00 001 00 0", acc_out, flags_out, retired_cnt, br_valid);
    end
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i);
      #1;
      tests++; if (rd_data !== 8'h00) begin fails++; $display("FAIL midreset_reg%0d got %h exp 00", i, rd_data); end
    end
    idle();
    model_reset();
    @(negedge clk) rst_n = 1;
    step();
    tests++; if (br_valid !== 1'b0 || retired_cnt !== 8'h00) begin fails++; $display("FAIL midreset_drop bv %b cnt %h exp 0 00", br_valid, retired_cnt); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_commit_acc();
    test_stall();
    test_branch();
    test_bypass();
    test_random();
    test_counter_wrap();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
